// File: rtl/axi_cmd_arbiter.sv
// Round-robin arbiter that shares one AXI4-Lite master command port among NUM_REQ requesters.
// Optional watchdog on the master done handshake is built when ARB_TIMEOUT_EN is defined.
module axi_cmd_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned ADDR_WIDTH     = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             busy,
  output logic                             start_write,
  output logic                             start_read,
  output logic [ADDR_WIDTH-1:0]            mst_addr,
  output logic [DATA_WIDTH-1:0]            mst_wdata,
  input  logic [DATA_WIDTH-1:0]            mst_rdata,
  input  logic                             mst_done
);

  localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StResp} state_e;

  state_e                  r_state;
  logic [GW-1:0]           r_last;
  logic [NUM_REQ-1:0]      r_grant_oh;
  logic                    r_write;
  logic [NUM_REQ-1:0]      r_req_ready;
  logic [NUM_REQ-1:0]      r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_busy;
  logic                    r_start_write;
  logic                    r_start_read;
  logic [ADDR_WIDTH-1:0]   r_mst_addr;
  logic [DATA_WIDTH-1:0]   r_mst_wdata;

  logic                    w_any;
  logic [GW-1:0]           w_pick;
  logic [NUM_REQ-1:0]      w_pick_oh;
  logic                    w_write;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_wdata;
  int unsigned             w_idx;

  // Scan downwards so the requester closest after r_last is assigned last and wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    w_idx  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = (int'(r_last) + k) % NUM_REQ;
      if (req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = GW'(w_idx);
      end
    end
  end

  always_comb begin
    w_pick_oh = '0;
    w_write   = 1'b0;
    w_addr    = '0;
    w_wdata   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick == GW'(i)) begin
        w_pick_oh[i] = 1'b1;
        w_write      = req_write[i];
        w_addr       = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_wdata      = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] r_cnt;
  logic          r_rsp_err;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_last        <= GW'(NUM_REQ - 1);
      r_grant_oh    <= '0;
      r_write       <= 1'b0;
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_busy        <= 1'b0;
      r_start_write <= 1'b0;
      r_start_read  <= 1'b0;
      r_mst_addr    <= '0;
      r_mst_wdata   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt         <= '0;
      r_rsp_err     <= 1'b0;
`endif
    end else begin
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_start_write <= 1'b0;
      r_start_read  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_state       <= StIssue;
            r_last        <= w_pick;
            r_grant_oh    <= w_pick_oh;
            r_write       <= w_write;
            r_req_ready   <= w_pick_oh;
            r_start_write <= w_write;
            r_start_read  <= ~w_write;
            r_mst_addr    <= w_addr;
            r_mst_wdata   <= w_wdata;
            r_busy        <= 1'b1;
          end
        end
        StIssue: begin
          r_state <= StWaitDone;
`ifdef ARB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        StWaitDone: begin
          if (mst_done) begin
            r_state     <= StResp;
            r_rsp_valid <= r_grant_oh;
            r_rsp_rdata <= r_write ? '0 : mst_rdata;
`ifdef ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= StResp;
            r_rsp_valid <= r_grant_oh;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
`endif
          end
        end
        StResp: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign busy        = r_busy;
  assign start_write = r_start_write;
  assign start_read  = r_start_read;
  assign mst_addr    = r_mst_addr;
  assign mst_wdata   = r_mst_wdata;
`ifdef ARB_TIMEOUT_EN
  assign rsp_err     = r_rsp_err;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: doc/axi_cmd_arbiter.md
Name: axi_cmd_arbiter

Overview:
- Shares the single AXI4-Lite master's user command interface among NUM_REQ requesters: start_write/start_read, write/read address, write data, read data and done.
- Accepts one command at a time from any requester.
- Arbitrates round-robin, sequences the master through the start/done handshake and returns read data or write completion to the granted requester.
- Sits between on-chip command sources (host shim, sequencer) and the axi4lite_master instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_WIDTH, 2, register address width; matches master.
- DATA_WIDTH, 8, data width; matches master.
- TIMEOUT_CYCLES, 255, watchdog limit in clk cycles; used only with ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester command valid; held until accepted.
- req_ready  output  NUM_REQ  one-cycle pulse on accept; at most one bit set.
- req_write  input  NUM_REQ  1=write, 0=read, per requester.
- req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data.
- rsp_valid  output  NUM_REQ  one-cycle completion pulse to the granted requester.
- rsp_rdata  output  DATA_WIDTH  read data; valid with rsp_valid; 0 for writes.
- rsp_err  output  1  timeout flag; valid with rsp_valid.
- busy  output  1  high in every state except IDLE.
- start_write  output  1  one-cycle write start to master.
- start_read  output  1  one-cycle read start to master.
- mst_addr  output  ADDR_WIDTH  address to master; drives both write_addr and read_addr.
- mst_wdata  output  DATA_WIDTH  write data to master.
- mst_rdata  input  DATA_WIDTH  master read_data; valid when mst_done=1.
- mst_done  input  1  master done pulse.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - All outputs 0.
  - RR pointer set so requester 0 wins first.
  - Internal registers cleared.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT_DONE, RESP.
- IDLE:
  - If any req_valid, select the first valid requester starting at (last_grant+1) mod NUM_REQ.
  - Latch its write flag, address and write data.
  - Update last_grant; go to ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - req_ready[g]=1.
  - start_write=write or start_read=!write.
  - mst_addr and mst_wdata driven from the latch.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - start_* = 0; mst_addr and mst_wdata held stable.
  - On mst_done=1: capture mst_rdata for reads (0 for writes); go to RESP.
  - mst_done is ignored in all other states.
- RESP (exactly 1 cycle):
  - rsp_valid[g]=1, rsp_rdata=captured value.
  - Go to IDLE.
- Latency and throughput:
  - Minimum latency from req_valid sampled in IDLE to rsp_valid is 3 cycles plus master latency.
  - Back-to-back commands have a 1-cycle IDLE gap.
- Fairness: both requesters continuously valid → grants alternate 0,1,0,1…; no starvation.
- Requester rules:
  - A requester must hold req_valid and payload until req_ready.
  - Deasserting req_valid in IDLE before grant withdraws the request; it is not served.
  - A new req_valid from the granted requester during WAIT_DONE/RESP is not accepted until the next IDLE.
- Reset mid-operation: immediate return to IDLE; no rsp_valid is issued for the in-flight command; the RR pointer is reset.
- With NUM_REQ=1: arbitration is trivial; timing is unchanged.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - An 8-bit+ counter clears on entry to WAIT_DONE and increments each WAIT_DONE cycle.
  - If it reaches TIMEOUT_CYCLES without mst_done: go to RESP with rsp_err=1 and rsp_rdata=0.
  - A later stray mst_done is ignored.
- Without the macro:
  - No counter is built; rsp_err is tied 0.
  - WAIT_DONE waits indefinitely.

Test Plan:
- Single write: req0 write addr=2 wdata=0xA5; master done 4 cycles after start.
  → Exactly one start_write pulse with mst_addr=2, mst_wdata=0xA5.
  → rsp_valid=01 with rsp_rdata=0x00 the cycle after done.
- Single read: req1 read addr=3; master returns 0x3C with done.
  → One start_read pulse with mst_addr=3.
  → rsp_valid=10 with rsp_rdata=0x3C.
- Contention: req0 and req1 both valid after reset, 4 commands each.
  → Grant order 0,1,0,1,0,1,0,1.
  → Exactly one req_ready per command; no overlap of start pulses.
- Withdraw plus stability: req1 valid one cycle while FSM busy with req0, then dropped.
  → req1 never granted; mst_addr/mst_wdata stable throughout WAIT_DONE.
- Reset mid-operation: rst asserted in WAIT_DONE.
  → All outputs 0 asynchronously; no rsp_valid.
  → Next request from req1 goes through after req0 is served first if both are valid.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=10): mst_done never asserted.
  → rsp_valid with rsp_err=1, rsp_rdata=0 after 10 WAIT_DONE cycles; busy then returns to 0.
